// File: rtl/and_gate_pkg.sv
// ---------------------------------------------------------------------------
// and_gate_pkg : parameter defaults shared by the and_gate block   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package and_gate_pkg;
    localparam int AND_WIDTH_DEF = 1;
    localparam int AND_CNT_W_DEF = 8;
endpackage

`default_nettype wire

// File: rtl/and_gate_core.sv
// ---------------------------------------------------------------------------
// and_gate_core : purely combinational bitwise AND of two vectors   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module and_gate_core
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = a_i & b_i;

endmodule

`default_nettype wire

// File: rtl/and_gate.sv
// ---------------------------------------------------------------------------
// and_gate : bitwise AND with registered copy, reduction flags, edge pulses
//            and a saturating all-ones cycle counter                rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_WIDTH_DEF,
    parameter int CNT_W = AND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             all_q,
    output logic             any_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_and;
    logic             w_new_all;

    logic [WIDTH-1:0] c_d;
    logic             all_d;
    logic             any_d;
    logic             rise_d, rise_q;
    logic             fall_d, fall_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    and_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i (a),
        .b_i (b),
        .y_o (w_and)
    );

    assign c         = w_and;
    assign w_new_all = &w_and;

    // all_q doubles as the previous-cycle state for edge detection.
    always_comb begin
        c_d    = c_q;
        all_d  = all_q;
        any_d  = any_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        cnt_d  = cnt_q;
        if (en) begin
            c_d    = w_and;
            all_d  = w_new_all;
            any_d  = |w_and;
            rise_d = w_new_all & ~all_q;
            fall_d = ~w_new_all & all_q;
            if (w_new_all && (cnt_q != C_CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q    <= '0;
            all_q  <= 1'b0;
            any_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            c_q    <= c_d;
            all_q  <= all_d;
            any_q  <= any_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rise     = rise_q;
    assign fall     = fall_q;
    assign high_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_and_gate.sv
// ---------------------------------------------------------------------------
// tb_and_gate : directed-vector bench for and_gate at three sizes   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_and_gate;

    logic clk;
    int   total;
    int   bad;

    // WIDTH=1, CNT_W=8
    logic       rst1, en1;
    logic [0:0] a1, b1, c1, cq1;
    logic       all1, any1, rise1, fall1;
    logic [7:0] cnt1;

    // WIDTH=8, CNT_W=8
    logic       rst8, en8;
    logic [7:0] a8, b8, c8, cq8;
    logic       all8, any8, rise8, fall8;
    logic [7:0] cnt8;

    // WIDTH=1, CNT_W=3
    logic       rst3, en3;
    logic [0:0] a3, b3, c3, cq3;
    logic       all3, any3, rise3, fall3;
    logic [2:0] cnt3;

    and_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .en(en1), .c(c1), .c_q(cq1),
        .all_q(all1), .any_q(any1), .rise(rise1), .fall(fall1), .high_cnt(cnt1)
    );

    and_gate #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .en(en8), .c(c8), .c_q(cq8),
        .all_q(all8), .any_q(any8), .rise(rise8), .fall(fall8), .high_cnt(cnt8)
    );

    and_gate #(.WIDTH(1), .CNT_W(3)) u_c3 (
        .clk(clk), .rst(rst3), .a(a3), .b(b3), .en(en3), .c(c3), .c_q(cq3),
        .all_q(all3), .any_q(any3), .rise(rise3), .fall(fall3), .high_cnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [0:0] tt_a [5];
    logic [0:0] tt_b [5];
    logic [0:0] tt_c [5];

    initial begin
        total = 0;
        bad   = 0;
        rst1 = 1'b1; en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        rst8 = 1'b1; en8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        rst3 = 1'b1; en3 = 1'b0; a3 = 1'b0; b3 = 1'b0;

        // Combinational truth table, no clock dependence
        tt_a = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tt_b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tt_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            a1 = tt_a[i];
            b1 = tt_b[i];
            #2;
            chk($sformatf("tt%0d_c", i), 32'(c1), 32'(tt_c[i]));
        end

        // Unknown operand
        a1 = 1'b0; b1 = 1'bx; #2;
        chk("x_a0_c", 32'(c1), 32'(1'b0));
        a1 = 1'b1; #2;
        chk("x_a1_c", 32'(c1), 32'(1'bx));
        a1 = 1'b0; b1 = 1'b0;

        // Reset for two cycles
        step();
        step();
        chk("rst_cq",   32'(cq1),   32'd0);
        chk("rst_all",  32'(all1),  32'd0);
        chk("rst_any",  32'(any1),  32'd0);
        chk("rst_rise", 32'(rise1), 32'd0);
        chk("rst_fall", 32'(fall1), 32'd0);
        chk("rst_cnt",  32'(cnt1),  32'd0);
        chk("rst8_cq",  32'(cq8),   32'd0);
        chk("rst3_cnt", 32'(cnt3),  32'd0);
        rst1 = 1'b0; rst8 = 1'b0; rst3 = 1'b0;

        // First all-ones sample
        a1 = 1'b1; b1 = 1'b1; en1 = 1'b1;
        step();
        chk("up_cq",   32'(cq1),   32'd1);
        chk("up_all",  32'(all1),  32'd1);
        chk("up_any",  32'(any1),  32'd1);
        chk("up_rise", 32'(rise1), 32'd1);
        chk("up_cnt",  32'(cnt1),  32'd1);
        step();
        chk("up2_rise", 32'(rise1), 32'd0);
        chk("up2_cq",   32'(cq1),   32'd1);
        chk("up2_cnt",  32'(cnt1),  32'd2);

        // Enable low: registers hold, c follows immediately
        en1 = 1'b0; b1 = 1'b0; #1;
        chk("hold_c", 32'(c1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold%0d_cq", i),   32'(cq1),   32'd1);
            chk($sformatf("hold%0d_cnt", i),  32'(cnt1),  32'd2);
            chk($sformatf("hold%0d_fall", i), 32'(fall1), 32'd0);
        end
        en1 = 1'b1;
        step();
        chk("fall_pulse", 32'(fall1), 32'd1);
        chk("fall_cq",    32'(cq1),   32'd0);
        chk("fall_all",   32'(all1),  32'd0);
        chk("fall_rise",  32'(rise1), 32'd0);
        chk("fall_cnt",   32'(cnt1),  32'd2);
        step();
        chk("fall_end", 32'(fall1), 32'd0);

        // Reset wins over enable; next enabled edge is a fresh first sample
        a1 = 1'b1; b1 = 1'b1; rst1 = 1'b1;
        step();
        chk("rpri_cq",  32'(cq1),  32'd0);
        chk("rpri_cnt", 32'(cnt1), 32'd0);
        rst1 = 1'b0;
        step();
        chk("rpost_rise", 32'(rise1), 32'd1);
        chk("rpost_cnt",  32'(cnt1),  32'd1);

        // Wide reduction
        a8 = 8'hF0; b8 = 8'h3C; #1;
        chk("w8_c", 32'(c8), 32'h30);
        en8 = 1'b1;
        step();
        chk("w8_cq",  32'(cq8),  32'h30);
        chk("w8_any", 32'(any8), 32'd1);
        chk("w8_all", 32'(all8), 32'd0);
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        chk("w8ff_all",  32'(all8),  32'd1);
        chk("w8ff_rise", 32'(rise8), 32'd1);
        chk("w8ff_cnt",  32'(cnt8),  32'd1);

        // Counter saturation at 7
        a3 = 1'b1; b3 = 1'b1; en3 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("sat%0d_cnt", i), 32'(cnt3), (i > 7) ? 32'd7 : 32'(i));
        end
        rst3 = 1'b1;
        step();
        chk("sat_rst_cnt", 32'(cnt3), 32'd0);
        rst3 = 1'b0;
        step();
        chk("sat_post_cnt",  32'(cnt3),  32'd1);
        chk("sat_post_rise", 32'(rise3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
